// File: rtl/fir_multichannel_serial.sv
// rtl/fir_multichannel_serial.sv - multichannel signed FIR on one shared MAC with banked coefficients
// Frames are accepted only in IDLE; coefficient writes outside IDLE wait in a one-entry pending slot.
module fir_multichannel_serial #(
    parameter int CHANNELS = 3,
    parameter int TAPS     = 16,
    parameter int BANKS    = 4,
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int SHIFT    = 14,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int BANK_W   = (BANKS > 1) ? $clog2(BANKS) : 1,
    parameter int IDX_W    = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                       sys_clk,
    input  logic                       reset,
    input  logic                       sample_valid,
    input  logic [CHANNELS*DATA_W-1:0] sample_data,
    output logic                       ready,
    input  logic [CHANNELS*BANK_W-1:0] bank_sel,
    input  logic                       update_en,
    input  logic [CH_W-1:0]            update_axis,
    input  logic [BANK_W-1:0]          update_bank,
    input  logic [IDX_W-1:0]           update_index,
    input  logic [COEF_W-1:0]          update_value,
    output logic                       update_ack,
    output logic                       update_overrun,
    output logic [CHANNELS*DATA_W-1:0] result,
    output logic                       result_valid,
    output logic                       data_interrupt,
    input  logic                       int_clear,
    output logic [7:0]                 drop_count
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + IDX_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT} state_t;

    state_t                     state_q;
    logic                       ready_q, drain_q, result_valid_q, irq_q;
    logic [CH_W-1:0]            ch_q;
    logic [IDX_W-1:0]           tap_q;
    logic [7:0]                 drop_q;
    logic [CHANNELS*DATA_W-1:0] result_q;

    logic signed [DATA_W-1:0]   x_q    [CHANNELS][TAPS];
    logic signed [COEF_W-1:0]   coef_q [CHANNELS][BANKS][TAPS];
    logic [BANK_W-1:0]          bank_q [CHANNELS];
    logic signed [DATA_W-1:0]   y_q    [CHANNELS];

    logic                       pend_q, ack_q, overrun_q;
    logic [CH_W-1:0]            pend_axis_q;
    logic [BANK_W-1:0]          pend_bank_q;
    logic [IDX_W-1:0]           pend_index_q;
    logic [COEF_W-1:0]          pend_value_q;

    logic                       v1_q, f1_q, l1_q;
    logic [CH_W-1:0]            c1_q;
    logic signed [PROD_W-1:0]   prod_q;
    logic signed [ACC_W-1:0]    acc_q;

    logic                       accept, upd_ok;
    logic signed [DATA_W-1:0]   x_sel;
    logic signed [COEF_W-1:0]   c_sel;
    logic signed [PROD_W-1:0]   prod_d;
    logic signed [ACC_W-1:0]    acc_d, shifted;
    logic signed [DATA_W-1:0]   sat_d;

    assign accept = sample_valid & ready_q;
    assign upd_ok = update_en && (int'(update_axis) < CHANNELS) &&
                    (int'(update_bank) < BANKS) && (int'(update_index) < TAPS);

    always_comb begin
        x_sel   = x_q[ch_q][tap_q];
        c_sel   = coef_q[ch_q][bank_q[ch_q]][tap_q];
        prod_d  = PROD_W'(x_sel) * PROD_W'(c_sel);
        acc_d   = f1_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
        shifted = acc_d >>> SHIFT;
        if (shifted > SAT_MAX)      sat_d = DATA_W'(SAT_MAX);
        else if (shifted < SAT_MIN) sat_d = DATA_W'(SAT_MIN);
        else                        sat_d = shifted[DATA_W-1:0];
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            ready_q        <= 1'b1;
            drain_q        <= 1'b0;
            ch_q           <= '0;
            tap_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            irq_q          <= 1'b0;
            drop_q         <= '0;
        end else begin
            result_valid_q <= 1'b0;
            if (int_clear) irq_q <= 1'b0;
            if (sample_valid && !ready_q && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            case (state_q)
                S_IDLE: if (accept) begin
                    state_q <= S_MAC;
                    ready_q <= 1'b0;
                    ch_q    <= '0;
                    tap_q   <= '0;
                    irq_q   <= 1'b0;
                end
                S_MAC: if (tap_q == IDX_W'(TAPS - 1)) begin
                    tap_q <= '0;
                    if (ch_q == CH_W'(CHANNELS - 1)) begin
                        state_q <= S_DRAIN;
                        drain_q <= 1'b0;
                    end else begin
                        ch_q <= ch_q + CH_W'(1);
                    end
                end else begin
                    tap_q <= tap_q + IDX_W'(1);
                end
                S_DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) state_q <= S_OUT;
                end
                S_OUT: begin
                    state_q        <= S_IDLE;
                    ready_q        <= 1'b1;
                    result_valid_q <= 1'b1;
                    irq_q          <= 1'b1;
                    for (int c = 0; c < CHANNELS; c++) result_q[c*DATA_W +: DATA_W] <= y_q[c];
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                bank_q[c] <= '0;
                for (int k = 0; k < TAPS; k++) x_q[c][k] <= '0;
            end
        end else if (accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                bank_q[c]  <= bank_sel[c*BANK_W +: BANK_W];
                x_q[c][0]  <= sample_data[c*DATA_W +: DATA_W];
                for (int k = 1; k < TAPS; k++) x_q[c][k] <= x_q[c][k-1];
            end
        end
    end

    // Two-stage MAC: product register, then accumulate; the last tap of a channel lands in y_q.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            v1_q   <= 1'b0;
            f1_q   <= 1'b0;
            l1_q   <= 1'b0;
            c1_q   <= '0;
            prod_q <= '0;
            acc_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) y_q[c] <= '0;
        end else begin
            v1_q   <= (state_q == S_MAC);
            f1_q   <= (tap_q == '0);
            l1_q   <= (tap_q == IDX_W'(TAPS - 1));
            c1_q   <= ch_q;
            prod_q <= prod_d;
            if (v1_q) begin
                acc_q <= acc_d;
                if (l1_q) y_q[c1_q] <= sat_d;
            end
        end
    end

    // Writes only land while IDLE, so a running frame always reads one consistent coefficient set.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int b = 0; b < BANKS; b++)
                    for (int k = 0; k < TAPS; k++)
                        coef_q[c][b][k] <= (k == 0) ? COEF_W'(1 << SHIFT) : '0;
            pend_q       <= 1'b0;
            pend_axis_q  <= '0;
            pend_bank_q  <= '0;
            pend_index_q <= '0;
            pend_value_q <= '0;
            ack_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (upd_ok) begin
                pend_axis_q  <= update_axis;
                pend_bank_q  <= update_bank;
                pend_index_q <= update_index;
                pend_value_q <= update_value;
            end
            if (ready_q) begin
                if (pend_q) begin
                    coef_q[pend_axis_q][pend_bank_q][pend_index_q] <= pend_value_q;
                    ack_q  <= 1'b1;
                    pend_q <= upd_ok;
                end else if (upd_ok) begin
                    coef_q[update_axis][update_bank][update_index] <= update_value;
                    ack_q <= 1'b1;
                end
            end else if (upd_ok) begin
                pend_q <= 1'b1;
                if (pend_q) overrun_q <= 1'b1;
            end
        end
    end

    assign ready          = ready_q;
    assign result         = result_q;
    assign result_valid   = result_valid_q;
    assign data_interrupt = irq_q;
    assign update_ack     = ack_q;
    assign update_overrun = overrun_q;
    assign drop_count     = drop_q;

endmodule

// File: tb/tb_fir_multichannel_serial.sv
// tb/tb_fir_multichannel_serial.sv - directed vector bench for fir_multichannel_serial
module tb_fir_multichannel_serial;
    localparam int C  = 3;
    localparam int T  = 16;
    localparam int DW = 16;

    logic            sys_clk = 1'b0;
    logic            reset;
    logic            sample_valid;
    logic [C*DW-1:0] sample_data;
    logic            ready;
    logic [5:0]      bank_sel;
    logic            update_en;
    logic [1:0]      update_axis;
    logic [1:0]      update_bank;
    logic [3:0]      update_index;
    logic [15:0]     update_value;
    logic            update_ack;
    logic            update_overrun;
    logic [C*DW-1:0] result;
    logic            result_valid;
    logic            data_interrupt;
    logic            int_clear;
    logic [7:0]      drop_count;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int acks;
    int rvs;

    typedef struct {
        logic [5:0] bs;
        int x0, x1, x2;
        int e0, e1, e2;
    } vec_t;
    vec_t vecs [8];

    fir_multichannel_serial dut (
        .sys_clk        (sys_clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .ready          (ready),
        .bank_sel       (bank_sel),
        .update_en      (update_en),
        .update_axis    (update_axis),
        .update_bank    (update_bank),
        .update_index   (update_index),
        .update_value   (update_value),
        .update_ack     (update_ack),
        .update_overrun (update_overrun),
        .result         (result),
        .result_valid   (result_valid),
        .data_interrupt (data_interrupt),
        .int_clear      (int_clear),
        .drop_count     (drop_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int res(input int c);
        logic signed [DW-1:0] v;
        v = result[c*DW +: DW];
        return int'(v);
    endfunction

    task automatic step();
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        update_en    = 1'b0;
        int_clear    = 1'b0;
        repeat (3) @(negedge sys_clk);
        reset = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic write_coef(input int ax, input int bk, input int ix, input int val,
                              input int exp_ack, input string nm);
        update_axis  = 2'(ax);
        update_bank  = 2'(bk);
        update_index = 4'(ix);
        update_value = 16'(val);
        update_en    = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        update_en = 1'b0;
        check(nm, int'(update_ack), exp_ack);
    endtask

    task automatic start_frame(input int x0, input int x1, input int x2);
        sample_data  = {16'(x2), 16'(x1), 16'(x0)};
        sample_valid = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        sample_valid = 1'b0;
        cyc = 0;
        check("ready_low_when_busy", int'(ready), 0);
        check("irq_clear_on_accept", int'(data_interrupt), 0);
    endtask

    task automatic finish_frame(input int e0, input int e1, input int e2, input string nm);
        while (!result_valid && cyc < 200) step();
        check({nm, "_latency"}, cyc, C*T + 3);
        check({nm, "_ch0"}, res(0), e0);
        check({nm, "_ch1"}, res(1), e1);
        check({nm, "_ch2"}, res(2), e2);
        check({nm, "_irq_set"}, int'(data_interrupt), 1);
        check({nm, "_ready_back"}, int'(ready), 1);
        step();
        check({nm, "_valid_one_cycle"}, int'(result_valid), 0);
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        bank_sel     = '0;
        update_en    = 1'b0;
        update_axis  = '0;
        update_bank  = '0;
        update_index = '0;
        update_value = '0;
        int_clear    = 1'b0;

        vecs[0] = '{6'b110101,   400,   -800,  40,   100,   -200, 40};
        vecs[1] = '{6'b110101,   400,   -800,  40,   200,   -400, 40};
        vecs[2] = '{6'b110101,   400,   -800,  40,   300,   -600, 40};
        vecs[3] = '{6'b110101,   400,   -800,  40,   400,   -800, 40};
        vecs[4] = '{6'b010101,     0,      0,   0,   300,   -600, 30};
        vecs[5] = '{6'b111111,     7,     -7,   0,     7,     -7,  0};
        vecs[6] = '{6'b010101,     0,     -3,   1,   101,   -203, 10};
        vecs[7] = '{6'b000000, 32767, -32768, 100, 32767, -32768, 199};

        do_reset();
        check("rst_ready", int'(ready), 1);
        check("rst_result_nonzero", int'(|result), 0);
        check("rst_result_valid", int'(result_valid), 0);
        check("rst_irq", int'(data_interrupt), 0);
        check("rst_ack", int'(update_ack), 0);
        check("rst_overrun", int'(update_overrun), 0);
        check("rst_drop", int'(drop_count), 0);

        // Reset coefficients are unity pass-through in every bank.
        bank_sel = '0;
        start_frame(100, -200, 32767);
        finish_frame(100, -200, 32767, "defaults");

        do_reset();
        for (int a = 0; a < C; a++)
            for (int k = 0; k < 4; k++)
                write_coef(a, 1, k, 4096, 1, $sformatf("wr_avg_a%0d_t%0d", a, k));
        for (int a = 0; a < C; a++)
            write_coef(a, 0, 0, 32767, 1, $sformatf("wr_sat_a%0d", a));

        for (int i = 0; i < 8; i++) begin
            bank_sel = vecs[i].bs;
            start_frame(vecs[i].x0, vecs[i].x1, vecs[i].x2);
            finish_frame(vecs[i].e0, vecs[i].e1, vecs[i].e2, $sformatf("vec%0d", i));
        end

        // Two updates land while the frame is busy; only the second may take effect.
        do_reset();
        bank_sel = 6'b101010;
        start_frame(1000, -1000, 2000);
        acks = 0;
        while (!result_valid && cyc < 200) begin
            if (cyc == 5) begin
                update_axis = 2'd0; update_bank = 2'd2; update_index = 4'd1;
                update_value = 16'd16384; update_en = 1'b1;
            end else if (cyc == 12) begin
                update_axis = 2'd0; update_bank = 2'd2; update_index = 4'd0;
                update_value = 16'd8192; update_en = 1'b1;
            end else begin
                update_en = 1'b0;
            end
            step();
            if (update_ack) acks++;
        end
        update_en = 1'b0;
        check("deferred_no_ack_while_busy", acks, 0);
        check("overrun_sticky", int'(update_overrun), 1);
        finish_frame(1000, -1000, 2000, "deferred_old_coefs");
        check("deferred_ack_after_idle", int'(update_ack), 1);
        acks = 0;
        repeat (4) begin
            step();
            if (update_ack) acks++;
        end
        check("deferred_single_ack", acks, 0);
        start_frame(600, 600, 600);
        finish_frame(300, 600, 600, "deferred_new_coefs");

        bank_sel = 6'b000000;
        start_frame(400, 400, 400);
        while (!result_valid && cyc < 200) begin
            if (cyc == 10) bank_sel = 6'b000010;
            step();
        end
        finish_frame(400, 400, 400, "bank_latched_old");
        start_frame(200, 200, 200);
        finish_frame(100, 200, 200, "bank_latched_new");

        write_coef(3, 0, 0, 123, 0, "bad_axis_no_ack");

        write_coef(1, 1, 0, 8192, 1, "wr_pair_t0");
        write_coef(1, 1, 1, 8192, 1, "wr_pair_t1");
        bank_sel = 6'b000100;
        start_frame(10, 100, 30);
        while (!result_valid && cyc < 200) begin
            sample_valid = (cyc == 3 || cyc == 7 || cyc == 11);
            if (sample_valid) sample_data = {3{16'd9999}};
            step();
        end
        sample_valid = 1'b0;
        finish_frame(10, 150, 30, "drop_frame");
        check("drop_count_3", int'(drop_count), 3);

        // int_clear coinciding with OUT must lose to the set.
        start_frame(5, 300, 7);
        while (!result_valid && cyc < 200) begin
            int_clear = (cyc == 50);
            step();
        end
        int_clear = 1'b0;
        finish_frame(5, 200, 7, "after_drops");
        int_clear = 1'b1;
        step();
        int_clear = 1'b0;
        check("int_clear", int'(data_interrupt), 0);

        bank_sel = '0;
        start_frame(1, 1, 1);
        repeat (20) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        rvs = 0;
        repeat (80) begin
            step();
            if (result_valid) rvs++;
        end
        check("abort_no_valid", rvs, 0);
        check("abort_ready", int'(ready), 1);
        check("abort_result_nonzero", int'(|result), 0);

        sample_valid = 1'b1;
        repeat (330) step();
        sample_valid = 1'b0;
        check("drop_saturates", int'(drop_count), 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
